// File: rtl/transmissao_face_serial.sv
// rtl/transmissao_face_serial.sv - face pixel frame transmitter over a UART start/done handshake
// Optional trailing XOR checksum byte: `TRANSMISSAO_CHECKSUM_EN
module transmissao_face_serial #(
    parameter int          LINHAS    = 3,
    parameter int          COLUNAS   = 3,
    parameter int          DATA_W    = 3,
    parameter int          ADDR_L    = 2,
    parameter int          ADDR_C    = 2,
    parameter logic [7:0]  CABECALHO = 8'h23
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              partida,
    input  logic [DATA_W-1:0] dados_pixel,
    output logic [ADDR_L-1:0] addr_linha,
    output logic [ADDR_C-1:0] addr_coluna,
    output logic              tx_partida,
    output logic [7:0]        tx_dados,
    input  logic              tx_pronto,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        ENVIA_CAB  = 4'd1,
        ESPERA_CAB = 4'd2,
        LE         = 4'd3,
        ENVIA      = 4'd4,
        ESPERA     = 4'd5,
        PROXIMO    = 4'd6,
        ENVIA_CHK  = 4'd7,
        ESPERA_CHK = 4'd8,
        FINAL      = 4'd9
    } t_estado;

    t_estado           r_estado;
    t_estado           w_proximo;
    logic [ADDR_L-1:0] r_linha;
    logic [ADDR_C-1:0] r_coluna;
    logic [7:0]        w_pixel;
    logic              w_col_ult;
    logic              w_lin_ult;

    assign w_col_ult = (r_coluna == ADDR_C'(COLUNAS - 1));
    assign w_lin_ult = (r_linha  == ADDR_L'(LINHAS - 1));

    always_comb begin
        w_pixel                = 8'h00;
        w_pixel[DATA_W-1:0]    = dados_pixel;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
            r_linha  <= '0;
            r_coluna <= '0;
        end else begin
            r_estado <= w_proximo;
            case (r_estado)
                INICIAL: begin
                    r_linha  <= '0;
                    r_coluna <= '0;
                end
                // Row-major walk; the final position is held until INICIAL clears it
                PROXIMO: begin
                    if (!w_col_ult) begin
                        r_coluna <= r_coluna + ADDR_C'(1);
                    end else if (!w_lin_ult) begin
                        r_coluna <= '0;
                        r_linha  <= r_linha + ADDR_L'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRANSMISSAO_CHECKSUM_EN
    logic [7:0] r_chk;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_chk <= 8'h00;
        end else if (r_estado == INICIAL) begin
            r_chk <= 8'h00;
        end else if (r_estado == ENVIA) begin
            r_chk <= r_chk ^ w_pixel;
        end
    end
`endif

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            INICIAL:    if (partida) w_proximo = ENVIA_CAB;
            ENVIA_CAB:  w_proximo = ESPERA_CAB;
            ESPERA_CAB: if (tx_pronto) w_proximo = LE;
            LE:         w_proximo = ENVIA;
            ENVIA:      w_proximo = ESPERA;
            ESPERA:     if (tx_pronto) w_proximo = PROXIMO;
            PROXIMO: begin
                if (!(w_col_ult && w_lin_ult)) begin
                    w_proximo = LE;
                end else begin
`ifdef TRANSMISSAO_CHECKSUM_EN
                    w_proximo = ENVIA_CHK;
`else
                    w_proximo = FINAL;
`endif
                end
            end
`ifdef TRANSMISSAO_CHECKSUM_EN
            ENVIA_CHK:  w_proximo = ESPERA_CHK;
            ESPERA_CHK: if (tx_pronto) w_proximo = FINAL;
`endif
            FINAL:      w_proximo = INICIAL;
            default:    w_proximo = INICIAL;
        endcase
    end

    always_comb begin
        tx_partida = 1'b0;
        tx_dados   = 8'h00;
        pronto     = 1'b0;
        case (r_estado)
            ENVIA_CAB: begin
                tx_partida = 1'b1;
                tx_dados   = CABECALHO;
            end
            ENVIA: begin
                tx_partida = 1'b1;
                tx_dados   = w_pixel;
            end
`ifdef TRANSMISSAO_CHECKSUM_EN
            ENVIA_CHK: begin
                tx_partida = 1'b1;
                tx_dados   = r_chk;
            end
`endif
            FINAL:   pronto = 1'b1;
            default: ;
        endcase
    end

    assign ocupado     = (r_estado != INICIAL);
    assign db_estado   = r_estado;
    assign addr_linha  = r_linha;
    assign addr_coluna = r_coluna;

endmodule
